// File: rtl/executer_p.sv
// executer_p: multi-cycle execute unit with byte/word register files, ALU, flags and memory handshake.
// ALU/LEA retire 2 clk after accept, LOAD/STORE 2 clk + wait states; cmdReady only in IDLE.
// Define EXECUTER_P_POSTINC_EN to post-increment the word register after LOAD/STORE.
module executer_p #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int NBREG  = 8,
   parameter int NWREG  = 4
) (
   input  logic                     clk,
   input  logic                     nReset,
   input  logic                     cmdValid,
   output logic                     cmdReady,
   input  logic [1:0]               cmdKind,
   input  logic                     aluM,
   input  logic [3:0]               aluOp,
   input  logic [$clog2(NBREG)-1:0] ra,
   input  logic [$clog2(NBREG)-1:0] rb,
   input  logic [$clog2(NBREG)-1:0] rd,
   input  logic [$clog2(NWREG)-1:0] ws,
   output logic                     memReq,
   output logic                     memWe,
   output logic [ADDR_W-1:0]        memAddr,
   output logic [DATA_W-1:0]        memWdata,
   input  logic                     memAck,
   input  logic [DATA_W-1:0]        memRdata,
   output logic                     done,
   output logic [7:0]               flagOut
);
   localparam int RB_W = $clog2(NBREG);
   localparam int WS_W = $clog2(NWREG);
   localparam int MSB  = DATA_W - 1;
   localparam int DW1  = DATA_W + 1;
   localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_LEA = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

   state_t             state_q, state_d;
   logic [1:0]         kind_q;
   logic               m_q;
   logic [3:0]         op_q;
   logic [RB_W-1:0]    rd_q;
   logic [WS_W-1:0]    ws_q;
   logic [DATA_W-1:0]  a_q, b_q, rdat_q;
   logic [ADDR_W-1:0]  w_q;
   logic [3:0]         flg_q;   // {V,S,Z,C}
   logic               ie_q;
   logic [DATA_W-1:0]  regs_q  [NBREG];
   logic [ADDR_W-1:0]  wregs_q [NWREG];

   logic [DATA_W-1:0]  opb, alu_r;
   logic [DATA_W:0]    sum;
   logic               cin, sub, arith, alu_c, alu_v;
   logic               is_mem, is_store;

   always_comb begin
      opb = b_q; cin = 1'b0; sub = 1'b0; arith = 1'b0;
      if (!m_q) begin
         case (op_q)
            4'd0: arith = 1'b1;
            4'd1: begin arith = 1'b1; cin = flg_q[0]; end
            4'd2: begin arith = 1'b1; sub = 1'b1; end
            4'd3: begin arith = 1'b1; sub = 1'b1; cin = flg_q[0]; end
            4'd4: begin arith = 1'b1; opb = DATA_W'(1); end
            4'd5: begin arith = 1'b1; sub = 1'b1; opb = DATA_W'(1); end
            default: ;
         endcase
      end
      // The extra top bit is carry-out for adds and borrow for subtracts.
      sum = sub ? ({1'b0, a_q} - {1'b0, opb} - DW1'(cin))
                : ({1'b0, a_q} + {1'b0, opb} + DW1'(cin));
      alu_r = '0; alu_c = 1'b0; alu_v = 1'b0;
      if (arith) begin
         alu_r = sum[DATA_W-1:0];
         alu_c = sum[DATA_W];
         alu_v = sub ? ((a_q[MSB] != opb[MSB]) && (alu_r[MSB] != a_q[MSB]))
                     : ((a_q[MSB] == opb[MSB]) && (alu_r[MSB] != a_q[MSB]));
      end else if (!m_q) begin
         case (op_q)
            4'd6: begin alu_r = {a_q[DATA_W-2:0], 1'b0}; alu_c = a_q[MSB]; end
            4'd7: begin alu_r = {1'b0, a_q[DATA_W-1:1]}; alu_c = a_q[0]; end
            default: ;
         endcase
      end else begin
         case (op_q)
            4'd0: alu_r = a_q & b_q;
            4'd1: alu_r = a_q | b_q;
            4'd2: alu_r = a_q ^ b_q;
            4'd3: alu_r = ~a_q;
            4'd4: alu_r = b_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cmdValid)
                    state_d = (cmdKind == K_LOAD || cmdKind == K_STORE) ? S_MEM : S_EXEC;
         S_EXEC: state_d = S_WB;
         S_MEM:  if (memAck) state_d = S_WB;
         S_WB:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   assign is_mem   = (state_q == S_MEM);
   assign is_store = (kind_q == K_STORE);
   assign cmdReady = (state_q == S_IDLE);
   assign done     = (state_q == S_WB);
   assign memReq   = is_mem;
   assign memWe    = is_mem && is_store;
   assign memAddr  = is_mem ? (w_q + ADDR_W'(b_q)) : '0;
   assign memWdata = (is_mem && is_store) ? a_q : '0;
   assign flagOut  = {2'b00, ie_q, 1'b0, flg_q};

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         kind_q <= '0; m_q <= 1'b0; op_q <= '0; rd_q <= '0; ws_q <= '0;
         a_q <= '0; b_q <= '0; w_q <= '0; rdat_q <= '0;
         flg_q <= '0; ie_q <= 1'b0;
         for (int i = 0; i < NBREG; i++) regs_q[i] <= '0;
         for (int i = 0; i < NWREG; i++) wregs_q[i] <= '0;
      end else begin
         if (cmdValid && cmdReady) begin
            kind_q <= cmdKind; m_q <= aluM; op_q <= aluOp; rd_q <= rd; ws_q <= ws;
            a_q <= regs_q[ra]; b_q <= regs_q[rb]; w_q <= wregs_q[ws];
         end
         if (is_mem && memAck) rdat_q <= memRdata;
         // Operands and flags stay stable from accept to WB, so the ALU result is taken here.
         if (state_q == S_WB) begin
            case (kind_q)
               K_ALU: begin
                  regs_q[rd_q] <= alu_r;
                  flg_q        <= {alu_v, alu_r[MSB], (alu_r == '0), alu_c};
               end
               K_LOAD: regs_q[rd_q] <= rdat_q;
               K_LEA:  wregs_q[ws_q] <= w_q + ADDR_W'($signed(a_q));
               default: ;
            endcase
`ifdef EXECUTER_P_POSTINC_EN
            if (kind_q == K_LOAD || kind_q == K_STORE) wregs_q[ws_q] <= w_q + ADDR_W'(1);
`endif
         end
      end
   end
endmodule

// File: tb/tb_executer_p.sv
// Self-checking bench for executer_p: directed ALU table, hand-written memory/LEA/reset sequences,
// and randomized commands compared against an arithmetic reference model.
module tb_executer_p;
   logic        clk = 1'b0;
   logic        nReset, cmdValid, cmdReady, aluM, memReq, memWe, memAck, done;
   logic [1:0]  cmdKind, ws;
   logic [3:0]  aluOp;
   logic [2:0]  ra, rb, rd;
   logic [15:0] memAddr;
   logic [7:0]  memWdata, memRdata, flagOut;

   always #5 clk = ~clk;

   executer_p dut (
      .clk(clk), .nReset(nReset), .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdKind(cmdKind), .aluM(aluM), .aluOp(aluOp), .ra(ra), .rb(rb), .rd(rd), .ws(ws),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memAck(memAck), .memRdata(memRdata), .done(done), .flagOut(flagOut)
   );

   typedef struct packed {
      logic [1:0] kind; logic m; logic [3:0] op;
      logic [2:0] ra; logic [2:0] rb; logic [2:0] rd; logic [1:0] ws;
   } cmd_t;

   typedef struct packed {
      logic m; logic [3:0] op; logic [7:0] a; logic [7:0] b; logic cin;
      logic [7:0] r; logic [3:0] f;
   } vec_t;

   int n_chk = 0, n_fail = 0;
   vec_t vt [21];

   logic [7:0]  m_r [8];
   logic [15:0] m_w [4];
   int mc, mz, ms, mv;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk(input int k, input int m, input int op, input int a,
                               input int b, input int d, input int w);
      cmd_t c;
      c.kind = 2'(k); c.m = 1'(m); c.op = 4'(op);
      c.ra = 3'(a); c.rb = 3'(b); c.rd = 3'(d); c.ws = 2'(w);
      return c;
   endfunction

   function automatic int sx8(input logic [7:0] x);
      return (int'(x) >= 128) ? int'(x) - 256 : int'(x);
   endfunction

   function automatic logic [7:0] model_flags();
      return {4'h0, 1'(mv), 1'(ms), 1'(mz), 1'(mc)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
      for (int i = 0; i < 4; i++) m_w[i] = 16'h0000;
      mc = 0; mz = 0; ms = 0; mv = 0;
   endtask

   task automatic model_exec(input cmd_t c, input logic [7:0] rdat,
                             output logic [15:0] e_addr, output logic [7:0] e_wd);
      int a, b, full, sfull, r, cf, vf, ar;
      a = int'(m_r[c.ra]); b = int'(m_r[c.rb]);
      e_addr = m_w[c.ws] + {8'h00, m_r[c.rb]};
      e_wd   = m_r[c.ra];
      full = 0; sfull = 0; cf = 0; vf = 0; ar = 0;
      case (c.kind)
         2'd0: begin
            if (!c.m) begin
               case (c.op)
                  4'd0: begin ar = 1; full = a + b;      sfull = sx8(m_r[c.ra]) + sx8(m_r[c.rb]);      cf = int'(full > 255); end
                  4'd1: begin ar = 1; full = a + b + mc; sfull = sx8(m_r[c.ra]) + sx8(m_r[c.rb]) + mc; cf = int'(full > 255); end
                  4'd2: begin ar = 1; full = a - b;      sfull = sx8(m_r[c.ra]) - sx8(m_r[c.rb]);      cf = int'(full < 0); end
                  4'd3: begin ar = 1; full = a - b - mc; sfull = sx8(m_r[c.ra]) - sx8(m_r[c.rb]) - mc; cf = int'(full < 0); end
                  4'd4: begin ar = 1; full = a + 1;      sfull = sx8(m_r[c.ra]) + 1;                   cf = int'(full > 255); end
                  4'd5: begin ar = 1; full = a - 1;      sfull = sx8(m_r[c.ra]) - 1;                   cf = int'(full < 0); end
                  4'd6: begin full = a * 2; cf = int'(a >= 128); end
                  4'd7: begin full = a / 2; cf = a % 2; end
                  default: full = 0;
               endcase
            end else begin
               case (c.op)
                  4'd0: full = int'(m_r[c.ra] & m_r[c.rb]);
                  4'd1: full = int'(m_r[c.ra] | m_r[c.rb]);
                  4'd2: full = int'(m_r[c.ra] ^ m_r[c.rb]);
                  4'd3: full = 255 - a;
                  4'd4: full = b;
                  default: full = 0;
               endcase
            end
            r = ((full % 256) + 256) % 256;
            if (ar != 0) vf = int'(sfull > 127 || sfull < -128);
            m_r[c.rd] = 8'(r);
            mc = cf; mv = vf; mz = int'(r == 0); ms = int'(r >= 128);
         end
         2'd1: m_r[c.rd] = rdat;
         2'd3: m_w[c.ws] = 16'((int'(m_w[c.ws]) + sx8(m_r[c.ra]) + 65536) % 65536);
         default: ;
      endcase
`ifdef EXECUTER_P_POSTINC_EN
      if (c.kind == 2'd1 || c.kind == 2'd2) m_w[c.ws] = m_w[c.ws] + 16'd1;
`endif
   endtask

   // Drives one command and plays memory with 'waits' wait states; returns what the DUT showed.
   task automatic run_cmd(input cmd_t c, input int waits, input logic [7:0] rdat,
                          output int lat, output logic [15:0] addr, output logic we,
                          output logic [7:0] wd, output int reqc);
      int n; bit got;
      @(negedge clk);
      check("ready_idle", cmdReady, 1);
      cmdKind = c.kind; aluM = c.m; aluOp = c.op; ra = c.ra; rb = c.rb; rd = c.rd; ws = c.ws;
      cmdValid = 1'b1;
      @(negedge clk);
      cmdValid = 1'b0;
      check("ready_busy", cmdReady, 0);
      n = 1; reqc = 0; got = 0; addr = '0; we = 1'b0; wd = '0; lat = -1;
      while (n < 40 && !got) begin
         if (done) begin
            got = 1; lat = n;
         end else begin
            if (memReq) begin
               reqc++; addr = memAddr; we = memWe; wd = memWdata;
               if (reqc == waits + 1) begin memAck = 1'b1; memRdata = rdat; end
            end
            @(negedge clk);
            memAck = 1'b0;
            n++;
         end
      end
      check("done_seen", 32'(got), 1);
      @(negedge clk);
      check("done_pulse", done, 0);
   endtask

   task automatic exec(input cmd_t c, input int waits, input logic [7:0] rdat,
                       output logic [15:0] addr_o, output logic [7:0] wd_o);
      int lat, reqc; logic we; logic [15:0] ea; logic [7:0] ew; bit mem;
      mem = (c.kind == 2'd1) || (c.kind == 2'd2);
      run_cmd(c, waits, rdat, lat, addr_o, we, wd_o, reqc);
      model_exec(c, rdat, ea, ew);
      check("latency", lat, mem ? waits + 2 : 2);
      check("req_cycles", reqc, mem ? waits + 1 : 0);
      check("flags", flagOut, model_flags());
      if (mem) begin
         check("mem_addr", addr_o, ea);
         check("mem_we", we, 32'(c.kind == 2'd2));
         if (c.kind == 2'd2) check("mem_wdata", wd_o, ew);
      end
   endtask

   task automatic set_reg(input int idx, input logic [7:0] v);
      logic [15:0] a; logic [7:0] d;
      exec(mk(1, 0, 0, 0, 0, idx, 3), 0, v, a, d);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] a; logic [7:0] d; cmd_t c; int w;
      nReset = 1'b0; cmdValid = 1'b0; cmdKind = '0; aluM = 1'b0; aluOp = '0;
      ra = '0; rb = '0; rd = '0; ws = '0; memAck = 1'b0; memRdata = '0;
      //           m     op     a      b      cin   r      {V,S,Z,C}
      vt[0]  = '{1'b0, 4'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100};
      vt[1]  = '{1'b0, 4'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011};
      vt[2]  = '{1'b0, 4'd1, 8'h05, 8'h02, 1'b1, 8'h08, 4'b0000};
      vt[3]  = '{1'b0, 4'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011};
      vt[4]  = '{1'b0, 4'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0101};
      vt[5]  = '{1'b0, 4'd3, 8'h05, 8'h02, 1'b1, 8'h02, 4'b0000};
      vt[6]  = '{1'b0, 4'd2, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1000};
      vt[7]  = '{1'b0, 4'd4, 8'h7F, 8'h00, 1'b0, 8'h80, 4'b1100};
      vt[8]  = '{1'b0, 4'd4, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b0011};
      vt[9]  = '{1'b0, 4'd5, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0101};
      vt[10] = '{1'b0, 4'd5, 8'h80, 8'h00, 1'b0, 8'h7F, 4'b1000};
      vt[11] = '{1'b0, 4'd6, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0001};
      vt[12] = '{1'b0, 4'd7, 8'h81, 8'h00, 1'b0, 8'h40, 4'b0001};
      vt[13] = '{1'b0, 4'd7, 8'h02, 8'h00, 1'b1, 8'h01, 4'b0000};
      vt[14] = '{1'b1, 4'd0, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000};
      vt[15] = '{1'b1, 4'd1, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0010};
      vt[16] = '{1'b1, 4'd2, 8'hFF, 8'h0F, 1'b0, 8'hF0, 4'b0100};
      vt[17] = '{1'b1, 4'd3, 8'h0F, 8'h55, 1'b1, 8'hF0, 4'b0100};
      vt[18] = '{1'b1, 4'd4, 8'h12, 8'h85, 1'b0, 8'h85, 4'b0100};
      vt[19] = '{1'b1, 4'd5, 8'h12, 8'h34, 1'b1, 8'h00, 4'b0010};
      vt[20] = '{1'b0, 4'd9, 8'h12, 8'h34, 1'b1, 8'h00, 4'b0010};
      model_reset();

      #22 nReset = 1'b1;
      @(negedge clk);
      check("rst_ready", cmdReady, 1);
      check("rst_memreq", memReq, 0);
      check("rst_done", done, 0);
      check("rst_flags", flagOut, 0);
      check("rst_memaddr", memAddr, 0);

      // Directed ALU table; C is primed by shifting 0x80 or 0x00 left.
      for (int i = 0; i < 21; i++) begin
         set_reg(1, vt[i].a);
         set_reg(2, vt[i].b);
         set_reg(7, vt[i].cin ? 8'h80 : 8'h00);
         exec(mk(0, 0, 6, 7, 0, 7, 0), 0, 8'h00, a, d);
         exec(mk(0, int'(vt[i].m), int'(vt[i].op), 1, 2, 3, 0), 0, 8'h00, a, d);
         check($sformatf("vec%0d_flags", i), flagOut, {4'h0, vt[i].f});
         exec(mk(2, 0, 0, 3, 0, 0, 3), 0, 8'h00, a, d);
         check($sformatf("vec%0d_result", i), d, vt[i].r);
      end

      // LOAD with a wrapping address and three wait states.
      set_reg(6, 8'hFF);
      exec(mk(3, 0, 0, 6, 0, 0, 0), 0, 8'h00, a, d);
      set_reg(2, 8'h02);
      set_reg(5, 8'h00);
      exec(mk(1, 0, 0, 0, 2, 4, 0), 3, 8'hA5, a, d);
      check("load_addr", a, 16'h0001);
      exec(mk(2, 0, 0, 4, 0, 0, 3), 0, 8'h00, a, d);
      check("load_data", d, 8'hA5);
      exec(mk(2, 0, 0, 0, 5, 0, 0), 0, 8'h00, a, d);
`ifdef EXECUTER_P_POSTINC_EN
      check("wreg0_after_load", a, 16'h0000);
`else
      check("wreg0_after_load", a, 16'hFFFF);
`endif

      // LEA: build wreg1 = 0x1000 (32*0x7F + 0x20), then add sign-extended 0xFE.
      set_reg(6, 8'h7F);
      repeat (32) exec(mk(3, 0, 0, 6, 0, 0, 1), 0, 8'h00, a, d);
      set_reg(6, 8'h20);
      exec(mk(3, 0, 0, 6, 0, 0, 1), 0, 8'h00, a, d);
      set_reg(1, 8'h7F);
      set_reg(2, 8'h01);
      exec(mk(0, 0, 0, 1, 2, 3, 0), 0, 8'h00, a, d);
      set_reg(6, 8'hFE);
      exec(mk(3, 0, 0, 6, 0, 0, 1), 0, 8'h00, a, d);
      check("lea_flags", flagOut, 8'h0C);
      exec(mk(2, 0, 0, 0, 5, 0, 1), 0, 8'h00, a, d);
      check("lea_wreg1", a, 16'h0FFE);

      // Reset while a LOAD waits in MEM.
      for (int i = 0; i < 8; i++) set_reg(i, 8'(i * 17 + 3));
      exec(mk(0, 0, 0, 7, 6, 0, 0), 0, 8'h00, a, d);
      @(negedge clk);
      cmdKind = 2'd1; aluM = 1'b0; aluOp = 4'd0; ra = 3'd0; rb = 3'd0; rd = 3'd1; ws = 2'd3;
      cmdValid = 1'b1;
      @(negedge clk);
      cmdValid = 1'b0;
      check("mem_before_rst", memReq, 1);
      #2 nReset = 1'b0;
      #1;
      check("rst_mid_memreq", memReq, 0);
      check("rst_mid_ready", cmdReady, 1);
      check("rst_mid_flags", flagOut, 0);
      check("rst_mid_memaddr", memAddr, 0);
      @(negedge clk);
      nReset = 1'b1; memAck = 1'b1; memRdata = 8'h5A;
      repeat (3) begin
         @(negedge clk);
         check("stray_ack_req", memReq, 0);
         check("stray_ack_done", done, 0);
      end
      memAck = 1'b0;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         exec(mk(2, 0, 0, 0, 0, 0, k), 0, 8'h00, a, d);
         check("rst_wreg", a, 16'h0000);
      end
      for (int i = 0; i < 8; i++) begin
         exec(mk(2, 0, 0, i, 0, 0, 3), 0, 8'h00, a, d);
         check("rst_reg", d, 8'h00);
      end

      // Randomized commands against the reference model.
      for (int t = 0; t < 250; t++) begin
         c = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 9),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3));
         w = $urandom_range(0, 3);
         exec(c, w, 8'($urandom), a, d);
      end
      for (int k = 0; k < 4; k++) exec(mk(2, 0, 0, 0, 0, 0, k), 0, 8'h00, a, d);
      for (int i = 0; i < 8; i++) exec(mk(2, 0, 0, i, 0, 0, 3), 0, 8'h00, a, d);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
